// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_pkg
// Brief    : Shared LED-matrix sizes and the row-scan state encoding.
// Revision : 1.0
// ============================================================================
package led_matrix_pkg;

    localparam int c_default_rows  = 14;
    localparam int c_default_cols  = 32;
    localparam int c_default_row_w = $clog2(c_default_rows);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_WAIT_ON = 3'd4,
        ST_BLANK   = 3'd5,
        ST_LATCH   = 3'd6,
        ST_SHOW    = 3'd7
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/led_scan_controller_shifter.sv
`default_nettype none
// ============================================================================
// Module   : sr_shifter
// Brief    : Serialises one row word MSB first onto sr_data/sr_clock.
// Revision : 1.0
// ============================================================================
module sr_shifter #(
    parameter int COLS    = 32,
    parameter int CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [COLS-1:0] load_word,
    output logic            sr_data,
    output logic            sr_clock,
    output logic            done
);

    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_bit_w = $clog2(COLS + 1);

    logic                r_active;
    logic                r_phase;
    logic [c_div_w-1:0]  r_div;
    logic [c_bit_w-1:0]  r_bits;
    logic [COLS-1:0]     r_shreg;
    logic                w_phase_end;

    assign w_phase_end = r_active && (r_div == c_div_w'(CLK_DIV - 1));
    assign done        = w_phase_end && r_phase && (r_bits == c_bit_w'(1));
    assign sr_clock    = r_active & r_phase;
    assign sr_data     = r_active & r_shreg[COLS-1];

    // The word only moves after a high phase, so sr_data is stable while sr_clock is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_phase  <= 1'b0;
            r_div    <= '0;
            r_bits   <= '0;
            r_shreg  <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_phase  <= 1'b0;
            r_div    <= '0;
            r_bits   <= c_bit_w'(COLS);
            r_shreg  <= load_word;
        end else if (r_active) begin
            if (w_phase_end) begin
                r_div   <= '0;
                r_phase <= ~r_phase;
                if (r_phase) begin
                    r_shreg <= {r_shreg[COLS-2:0], 1'b0};
                    r_bits  <= r_bits - 1'b1;
                    if (r_bits == c_bit_w'(1)) begin
                        r_active <= 1'b0;
                    end
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_controller
// Brief    : Row-scan sequencer: fetch, shift, blank, latch and gate each row.
// Revision : 1.0
// ============================================================================
module led_scan_controller
    import led_matrix_pkg::*;
#(
    parameter int ROWS        = c_default_rows,
    parameter int COLS        = c_default_cols,
    parameter int CLK_DIV     = 2,
    parameter int ON_CYCLES   = 1024,
    parameter int DEAD_CYCLES = 4,
    parameter int ROW_W       = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             fb_rd_en,
    output logic [ROW_W-1:0] fb_row,
    input  logic [COLS-1:0]  fb_data,
    output logic             sr_data,
    output logic             sr_clock,
    output logic             sr_latch,
    output logic             sr_enable,
    output logic [ROWS-1:0]  fet_gate,
    output logic             frame_start,
    output logic             busy
);

    localparam int c_tmr_w = $clog2(ON_CYCLES + 1);
    localparam int c_cnt_max = (DEAD_CYCLES > CLK_DIV) ? DEAD_CYCLES : CLK_DIV;
    localparam int c_cnt_w = $clog2(c_cnt_max + 1);

    scan_state_t         r_state;
    scan_state_t         w_next;
    logic [ROW_W-1:0]    r_next_row;
    logic [c_tmr_w-1:0]  r_timer;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [ROWS-1:0]     r_fet_gate;
    logic                r_sr_enable;
    logic                w_shift_start;
    logic                w_shift_done;
    logic                w_timer_done;
    logic                w_enter_show;
    logic                w_enter_blank;

    assign w_timer_done  = (r_timer == '0);
    assign w_shift_start = (r_state == ST_CAPTURE);
    assign w_enter_show  = (r_state == ST_LATCH) && (w_next == ST_SHOW);
    assign w_enter_blank = (r_state != ST_BLANK) && (w_next == ST_BLANK);
    assign fet_gate      = r_fet_gate;
    assign sr_enable     = r_sr_enable;

    sr_shifter #(
        .COLS    (COLS),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .start     (w_shift_start),
        .load_word (fb_data),
        .sr_data   (sr_data),
        .sr_clock  (sr_clock),
        .done      (w_shift_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        fb_rd_en    = 1'b0;
        fb_row      = '0;
        sr_latch    = 1'b0;
        frame_start = 1'b0;
        busy        = (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE: begin
                if (enable) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                fb_rd_en = 1'b1;
                fb_row   = r_next_row;
                w_next   = ST_CAPTURE;
            end
            ST_CAPTURE: w_next = ST_SHIFT;
            // An already expired on-time skips the WAIT_ON dwell so the row period stays exact.
            ST_SHIFT: begin
                if (w_shift_done) w_next = w_timer_done ? ST_BLANK : ST_WAIT_ON;
            end
            ST_WAIT_ON: begin
                if (w_timer_done) w_next = ST_BLANK;
            end
            ST_BLANK: begin
                if (r_cnt == c_cnt_w'(DEAD_CYCLES - 1)) w_next = enable ? ST_LATCH : ST_IDLE;
            end
            ST_LATCH: begin
                sr_latch = 1'b1;
                if (r_cnt == c_cnt_w'(CLK_DIV - 1)) w_next = ST_SHOW;
            end
            ST_SHOW: begin
                frame_start = (r_next_row == '0);
                w_next      = ST_FETCH;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Gate, enable and on-timer all switch on the LATCH->SHOW edge, so the row is lit from SHOW on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_next_row  <= '0;
            r_timer     <= '0;
            r_cnt       <= '0;
            r_fet_gate  <= '0;
            r_sr_enable <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == ST_BLANK || r_state == ST_LATCH) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == ST_IDLE) begin
                r_timer <= '0;
            end else if (w_enter_show) begin
                r_timer <= c_tmr_w'(ON_CYCLES);
            end else if (!w_timer_done) begin
                r_timer <= r_timer - 1'b1;
            end

            if (w_enter_show) begin
                r_fet_gate  <= ROWS'(1) << r_next_row;
                r_sr_enable <= 1'b1;
            end else if (w_enter_blank) begin
                r_fet_gate  <= '0;
                r_sr_enable <= 1'b0;
            end

            if (r_state == ST_SHOW) begin
                r_next_row <= (r_next_row == ROW_W'(ROWS - 1)) ? '0 : r_next_row + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_scan_controller
// Brief    : Scoreboard bench for led_scan_controller (plus a long-shift instance).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_led_scan_controller;

    localparam int ROWS        = 14;
    localparam int COLS        = 8;
    localparam int CLK_DIV     = 1;
    localparam int ON_CYCLES   = 40;
    localparam int DEAD_CYCLES = 2;
    localparam int ROW_W       = 4;
    localparam int PERIOD      = 44;   // max(40, 18) + 2 + 1 + 1
    localparam int LIT         = 41;   // SHOW cycle + 40 on-cycles
    localparam int L_PERIOD    = 73;   // max(10, 66) + 2 + 4 + 1
    localparam int L_LIT       = 67;   // SHOW cycle + 66

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             en_long = 1'b0;
    logic [COLS-1:0]  fb_data = '0;
    logic [COLS-1:0]  l_fb_data = 8'h3C;

    logic             fb_rd_en, sr_data, sr_clock, sr_latch, sr_enable, frame_start, busy;
    logic [ROW_W-1:0] fb_row;
    logic [ROWS-1:0]  fet_gate;
    logic             l_fb_rd_en, l_sr_data, l_sr_clock, l_sr_latch, l_sr_enable, l_frame_start, l_busy;
    logic [ROW_W-1:0] l_fb_row;
    logic [ROWS-1:0]  l_fet_gate;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int nbits    = 0;

    int              exp_rd[$];
    logic [COLS-1:0] exp_byte[$];
    logic [ROWS-1:0] exp_gate[$];

    led_scan_controller #(
        .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV),
        .ON_CYCLES(ON_CYCLES), .DEAD_CYCLES(DEAD_CYCLES)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fb_rd_en(fb_rd_en), .fb_row(fb_row), .fb_data(fb_data),
        .sr_data(sr_data), .sr_clock(sr_clock), .sr_latch(sr_latch),
        .sr_enable(sr_enable), .fet_gate(fet_gate),
        .frame_start(frame_start), .busy(busy)
    );

    led_scan_controller #(
        .ROWS(ROWS), .COLS(COLS), .CLK_DIV(4),
        .ON_CYCLES(10), .DEAD_CYCLES(DEAD_CYCLES)
    ) u_long (
        .clk(clk), .rst(rst), .enable(en_long),
        .fb_rd_en(l_fb_rd_en), .fb_row(l_fb_row), .fb_data(l_fb_data),
        .sr_data(l_sr_data), .sr_clock(l_sr_clock), .sr_latch(l_sr_latch),
        .sr_enable(l_sr_enable), .fet_gate(l_fet_gate),
        .frame_start(l_frame_start), .busy(l_busy)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [COLS-1:0] byte_for(input int r);
        return (r == 0) ? 8'hA5 : 8'(r);
    endfunction

    task automatic push_row(input int r, input bit with_gate);
        exp_rd.push_back(r);
        exp_byte.push_back(byte_for(r));
        if (with_gate) exp_gate.push_back(14'(1) << r);
    endtask

    task automatic wait_gate(input logic [ROWS-1:0] v, input int max_cyc, input string name, output int n);
        n = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            n = i;
            if (fet_gate === v) break;
        end
        check(name, 32'(fet_gate), 32'(v));
    endtask

    // Frame buffer: data for the addressed row appears one cycle after the strobe.
    initial begin
        logic [COLS-1:0] fb_mem [ROWS];
        fb_mem[0] = 8'hA5;
        for (int r = 1; r < ROWS; r++) fb_mem[r] = 8'(r);
        forever begin
            @(negedge clk);
            if (fb_rd_en && int'(fb_row) < ROWS) fb_data = fb_mem[fb_row];
        end
    end

    // Main monitor: pops the scoreboard on reads, completed bytes and new row gates.
    initial begin
        logic [ROWS-1:0] prev_gate = '0;
        logic            prev_en = 1'b0, prev_clk = 1'b0, hold_data = 1'b0;
        logic [COLS-1:0] acc = '0;
        int              low_run = 0, latch_run = 0, fs_count = 0, fs_cycle = 0, e;
        forever begin
            @(negedge clk);
            if (rst) begin
                nbits = 0;
                latch_run = 0;
            end else begin
                if (fb_rd_en) begin
                    e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 255;
                    check("read_row", 32'(fb_row), 32'(e));
                end
                if (sr_clock && !prev_clk) begin
                    acc = {acc[COLS-2:0], sr_data};
                    hold_data = sr_data;
                    nbits++;
                    if (nbits == COLS) begin
                        check("shift_byte", 32'(acc), (exp_byte.size() > 0) ? 32'(exp_byte.pop_front()) : 32'hFFFF);
                        nbits = 0;
                    end
                end else if (sr_clock) begin
                    check("sr_data_stable", 32'(sr_data), 32'(hold_data));
                end
                if (sr_latch) begin
                    latch_run++;
                    check("latch_gate_dark", 32'(fet_gate), 32'd0);
                end else if (latch_run != 0) begin
                    check("latch_width", 32'(latch_run), 32'(CLK_DIV));
                    latch_run = 0;
                end
                if (fet_gate !== prev_gate) begin
                    check("gate_onehot", 32'($countones(fet_gate) <= 1), 32'd1);
                    if (fet_gate != '0) begin
                        check("gate_row", 32'(fet_gate), (exp_gate.size() > 0) ? 32'(exp_gate.pop_front()) : 32'hFFFF);
                        check("gate_while_dark", 32'(prev_en), 32'd0);
                        check("dead_time", 32'(low_run >= DEAD_CYCLES), 32'd1);
                        check("frame_start", 32'(frame_start), 32'(fet_gate == 14'h0001));
                        if (frame_start) begin
                            fs_count++;
                            if (fs_count == 2) check("frame_period", 32'(cycle - fs_cycle), 32'(ROWS * PERIOD));
                            fs_cycle = cycle;
                        end
                    end else begin
                        check("gate_off_dark", 32'(sr_enable), 32'd0);
                    end
                end else if (frame_start) begin
                    check("frame_start_stray", 32'(frame_start), 32'd0);
                end
            end
            low_run   = sr_enable ? 0 : low_run + 1;
            prev_gate = fet_gate;
            prev_en   = sr_enable;
            prev_clk  = sr_clock;
        end
    end

    // Long-shift instance: the row stays lit until the 64-cycle shift completes.
    initial begin
        logic [ROWS-1:0] l_prev_gate = '0;
        int              l_rises = 0, l_rise_cycle = 0, l_en_run = 0, l_runs = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (l_fet_gate !== l_prev_gate && l_fet_gate != '0) begin
                    if (l_rises >= 1 && l_rises <= 3) check("long_period", 32'(cycle - l_rise_cycle), 32'(L_PERIOD));
                    l_rises++;
                    l_rise_cycle = cycle;
                end
                if (l_sr_enable) begin
                    l_en_run++;
                end else if (l_en_run != 0) begin
                    if (l_runs < 3) begin
                        check("long_lit", 32'(l_en_run), 32'(L_LIT));
                        l_runs++;
                    end
                    l_en_run = 0;
                end
            end
            l_prev_gate = l_fet_gate;
        end
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({fb_rd_en, fb_row, sr_data, sr_clock, sr_latch, sr_enable,
                                    fet_gate, frame_start, busy}), 32'd0);
        check("reset_long", 32'({l_fet_gate, l_sr_enable, l_busy}), 32'd0);

        for (int k = 0; k < 20; k++) push_row(k % ROWS, 1'b1);
        push_row(6, 1'b0);
        rst = 1'b0;
        enable = 1'b1;
        en_long = 1'b1;

        wait_gate(14'h0001, 50, "first_row", n);
        wait_gate(14'h2000, ROWS * PERIOD, "last_row", n);
        wait_gate(14'h0001, 2 * PERIOD, "wrap_row", n);
        wait_gate(14'h0020, 6 * PERIOD, "row5_again", n);

        enable = 1'b0;
        wait_gate(14'h0000, 2 * PERIOD, "row5_off", n);
        check("row5_lit_cycles", 32'(n), 32'(LIT));
        repeat (DEAD_CYCLES) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_dark", 32'({fet_gate, sr_enable}), 32'd0);
        repeat (10) @(negedge clk);
        check("idle_hold", 32'({busy, fet_gate}), 32'd0);

        push_row(6, 1'b1);
        exp_rd.push_back(7);
        enable = 1'b1;
        wait_gate(14'h0040, 2 * PERIOD, "resume_row6", n);

        n = 0;
        while (nbits != 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_bit3", 32'(nbits), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_shift", 32'({fb_rd_en, fb_row, sr_data, sr_clock, sr_latch, sr_enable,
                                      fet_gate, frame_start, busy}), 32'd0);
        push_row(0, 1'b1);
        push_row(1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_gate(14'h0001, 50, "restart_row0", n);

        repeat (25) @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("final_idle", 32'({busy, fet_gate}), 32'd0);
        check("queues_drained", 32'(exp_rd.size() + exp_byte.size() + exp_gate.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/led_scan_controller.md
Name: led_scan_controller

Overview:
- Row-scan sequencer for the bulletin-board LED matrix.
- Fetches one row of pixel bits from the frame buffer read port and shifts it serially into the column shift-register chain (sr_data/sr_clock).
- Then blanks, latches and switches the one-hot FET row gate (fet_gate) to that row.
- Shifting of row r+1 overlaps display of row r. Sits between the SPI-fed frame buffer and the board's driver pins.

Parameters:
- ROWS, 14, number of FET-driven rows; fet_gate width.
- COLS, 32, column bits per row, shifted MSB first.
- CLK_DIV, 2, clk cycles per sr_clock half-period (≥1).
- ON_CYCLES, 1024, minimum clk cycles a row is lit.
- DEAD_CYCLES, 4, blanking cycles before latch (≥1).
- ROW_W, $clog2(ROWS), row index width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  1 = scan running; 0 = stop at next row boundary.
- fb_rd_en  out  1  one-cycle read strobe to frame buffer.
- fb_row  out  ROW_W  row address for the read; valid with fb_rd_en.
- fb_data  in  COLS  row bits; valid exactly 1 cycle after fb_rd_en.
- sr_data  out  1  serial column data.
- sr_clock  out  1  shift clock; the register samples on its rising edge.
- sr_latch  out  1  storage-register latch pulse, active-high.
- sr_enable  out  1  column output enable, 1 = columns driven.
- fet_gate  out  ROWS  one-hot row gate, 1 = row on.
- frame_start  out  1  one-cycle pulse when row 0 is gated on.
- busy  out  1  high whenever not in IDLE.

Behaviour:
- Reset (sync, active-high) on the next rising edge:
  - all outputs 0; fet_gate = 0; state IDLE; next_row = 0; timer cleared.
  - Applies mid-shift or mid-show; any partial shift is abandoned.
- Main FSM: IDLE, FETCH, CAPTURE, SHIFT, WAIT_ON, BLANK, LATCH, SHOW.
- IDLE:
  - fet_gate = 0, sr_enable = 0.
  - enable = 1 → FETCH.
- FETCH: fb_rd_en = 1, fb_row = next_row, for 1 cycle → CAPTURE.
- CAPTURE: load fb_data into the COLS-bit shift register; bit counter = COLS → SHIFT.
- SHIFT:
  - Per bit: sr_data = shreg[COLS-1] with sr_clock low for CLK_DIV cycles, then sr_clock high for CLK_DIV cycles.
  - sr_data is stable across the whole high phase.
  - Shift left after the high phase.
  - After COLS bits, sr_clock returns low → WAIT_ON.
  - Total shift = 2·CLK_DIV·COLS cycles.
- WAIT_ON: holds until on_timer_done → BLANK.
  - on_timer_done is 1 after reset or IDLE.
  - If shifting exceeds ON_CYCLES, the current row simply stays lit longer; there is no error and no glitch.
- BLANK:
  - fet_gate = 0, sr_enable = 0 for DEAD_CYCLES.
  - Then: enable = 0 → IDLE; otherwise → LATCH.
- LATCH: sr_latch = 1 for CLK_DIV cycles, fet_gate and sr_enable still 0 → SHOW.
- SHOW, for 1 cycle:
  - fet_gate = 1 << next_row; sr_enable = 1.
  - Load the on-timer with ON_CYCLES and start it.
  - frame_start = 1 iff next_row == 0.
  - next_row += 1, wrapping ROWS-1 → 0.
  - Go to FETCH. fet_gate and sr_enable persist through FETCH/CAPTURE/SHIFT/WAIT_ON until the next BLANK.
- Invariants:
  - fet_gate is never multi-hot.
  - fet_gate changes only while sr_enable = 0.
  - sr_latch is never high while fet_gate ≠ 0.
- enable deassertion:
  - Is sampled only in BLANK.
  - The current row finishes its ON time, then goes dark.
  - next_row is kept, so re-enable resumes at the next row.
- On-timer: down-counter, width $clog2(ON_CYCLES+1), saturates at 0.
- Per-row period is max(ON_CYCLES, 2·CLK_DIV·COLS + 2) + DEAD_CYCLES + CLK_DIV + 1 cycles.

Decomposition:
- Shared package `led_matrix_pkg`: ROWS, COLS defaults, ROW_W, and the state enum (scan_state_t) for bench visibility.
- One sub-module, `sr_shifter`:
  - Inputs: start, COLS-bit load word, CLK_DIV.
  - Outputs: sr_data, sr_clock, done pulse.
  - Owns the bit counter and divider.
- The FSM, on-timer and row pointer stay in `led_scan_controller`.

Test Plan:
- Bench config: ROWS=14, COLS=8, CLK_DIV=1, ON_CYCLES=40, DEAD_CYCLES=2.
- Basic row: rst 2 cycles, enable=1, fb_data=8'hA5 for row 0 → fb_rd_en at cycle 1 with fb_row=0; sr_data bits 1,0,1,0,0,1,0,1 on 8 sr_clock rising edges; sr_latch 1 cycle; fet_gate=14'h0001 with frame_start=1.
- Full frame wrap: run 15 rows with fb_data=row index → fet_gate walks 0x0001…0x2000, then 0x0001 again; second frame_start pulse exactly 14 row periods after the first; a checker confirms fet_gate is never multi-hot.
- Blanking invariant: monitor every cycle → each fet_gate change occurs with sr_enable=0, at least DEAD_CYCLES after it fell; sr_latch never high with fet_gate≠0.
- Long shift: COLS=8, CLK_DIV=4, ON_CYCLES=10 → row stays lit until the 64-cycle shift completes, then BLANK; no early switch.
- Disable mid-show: enable→0 while row 5 is lit → row 5 stays on until ON expires, then fet_gate=0, busy=0; re-enable → first gated row is 6.
- Reset mid-shift: assert rst during bit 3 of SHIFT → next cycle all outputs 0; after release + enable, the scan restarts at row 0 with a full 8-bit shift.
